pipeline_writeback: RTL

Final (write-back) stage of the PSRV32 pipeline and the writer side of the register-file interface that the decode stage reads. It accepts one completed instruction per handshake from the memory stage, waits for load data when required, aligns and sign/zero-extends load bytes, and presents a single-cycle register write (`write_reg` / `write_data` / `reg_write`) to the register file. It also back-pressures the memory stage while a load response is outstanding.

---
 rtl/pipeline_writeback.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_writeback.sv
// pipeline_writeback: write-back stage of the PSRV32 pipeline.
// Accepts one completed instruction per handshake. For a load it waits for
// the read response, then aligns and extends the load data. The result is
// presented to the register file as a single-cycle write.
//
// Optional feature: define PIPELINE_WB_INSTRET_EN to build a 64-bit
// retired-instruction counter on instret_o. Without it, instret_o is 0.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | empty, ready to accept
// WAIT_MEM | load latched, waiting for mem_rvalid_i
// WRITE    | result held, driven to the register file this cycle
module pipeline_writeback #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  input  logic [4:0]      rd_i,
  input  logic            reg_write_i,
  input  logic            mem_to_reg_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [4:0]      write_reg_o,
  output logic [XLEN-1:0] write_data_o,
  output logic            reg_write_o,
  output logic            stall_o,
  output logic [63:0]     instret_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [XLEN-1:0] data_q, data_d;

  logic            accept;
  logic            latch_en;
  logic            load_en;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_data;

  // The stage can take a new instruction unless a load is outstanding.
  assign ready_o = (state_q != WAIT_MEM);
  assign stall_o = (state_q == WAIT_MEM);
  assign accept  = valid_i && ready_o && !flush_i;

  // Next-state logic; flush overrides every transition and blocks accept.
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    load_en  = 1'b0;
    case (state_q)
      IDLE, WRITE: begin
        if (accept) begin
          latch_en = 1'b1;
          state_d  = mem_to_reg_i ? WAIT_MEM : WRITE;
        end else begin
          state_d  = IDLE;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid_i) begin
          load_en = 1'b1;
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d  = IDLE;
      latch_en = 1'b0;
      load_en  = 1'b0;
    end
  end

  // Select the addressed byte and half-word of the read response.
  always_comb begin
    load_byte = mem_rdata_i[7:0];
    case (addr_lo_q)
      2'd0: load_byte = mem_rdata_i[7:0];
      2'd1: load_byte = mem_rdata_i[15:8];
      2'd2: load_byte = mem_rdata_i[23:16];
      2'd3: load_byte = mem_rdata_i[31:24];
      default: load_byte = mem_rdata_i[7:0];
    endcase
    load_half = addr_lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
  end

  // Extend according to the load size/sign; unused encodings act as LW.
  always_comb begin
    case (funct3_q)
      3'b000:  load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
      3'b001:  load_data = {{(XLEN-16){load_half[15]}}, load_half};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, load_byte};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, load_half};
      default: load_data = mem_rdata_i;
    endcase
  end

  // Next values of the latched instruction fields and result data.
  always_comb begin
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    data_d      = data_q;
    if (latch_en) begin
      rd_d        = rd_i;
      reg_write_d = reg_write_i;
      funct3_d    = funct3_i;
      addr_lo_d   = addr_lo_i;
      data_d      = alu_result_i;
    end else if (load_en) begin
      data_d      = load_data;
    end
  end

  // State and latched-field registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      data_q      <= data_d;
    end
  end

  // Writes to x0 are suppressed here so the register file need not check.
  assign reg_write_o  = (state_q == WRITE) && reg_write_q && (rd_q != 5'd0);
  assign write_reg_o  = rd_q;
  assign write_data_o = data_q;

`ifdef PIPELINE_WB_INSTRET_EN
  logic [63:0] instret_q;

  // Count every retirement, including one that coincides with a flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instret_q <= 64'd0;
    end else if (state_q == WRITE) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = 64'd0;
`endif

endmodule
